// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one memory_access controller between NREQ requesters.
// Registers the winner, waits for HANDSHAKE, returns read data or aborts on timeout.
module mem_access_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [NREQ-1:0]      REQ,
    input  logic [3*NREQ-1:0]    REQ_CTRL,
    input  logic [48*NREQ-1:0]   REQ_ADDRESS,
    output logic [NREQ-1:0]      GRANT,
    output logic [NREQ-1:0]      DONE,
    output logic [NREQ-1:0]      ERR,
    output logic [47:0]          RD_DATA,
    output logic                 BUSY,
    output logic                 TIMEOUT_SEEN,
    output logic                 MEM_ENABLE,
    output logic [2:0]           MEM_CTRL,
    output logic [47:0]          MEM_ADDRESS,
    input  logic [47:0]          MEM_READ,
    input  logic                 MEM_HANDSHAKE
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] err_q, err_d;
    logic [47:0]     rd_q, rd_d;
    logic            seen_q, seen_d;
    logic            en_q, en_d;
    logic [2:0]      ctrl_q, ctrl_d;
    logic [47:0]     addr_q, addr_d;
    logic [IW-1:0]   last_q, last_d;
    logic [15:0]     cnt_q, cnt_d;

    logic [2:0]      ctrl_a [NREQ];
    logic [47:0]     addr_a [NREQ];
    logic            found;
    logic [IW-1:0]   win;

    for (genvar g = 0; g < NREQ; g++) begin : g_split
        assign ctrl_a[g] = REQ_CTRL[3*g +: 3];
        assign addr_a[g] = REQ_ADDRESS[48*g +: 48];
    end

    // First set request bit, searching upward from last+1 with wrap.
    always_comb begin
        int            cand;
        logic [IW-1:0] cidx;
        found = 1'b0;
        win   = last_q;
        cand  = 0;
        cidx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(last_q) + 1 + i;
            if (cand >= NREQ) cand = cand - NREQ;
            cidx = cand[IW-1:0];
            if (!found && REQ[cidx]) begin
                found = 1'b1;
                win   = cidx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = '0;
        rd_d    = rd_q;
        seen_d  = seen_q;
        en_d    = en_q;
        ctrl_d  = ctrl_q;
        addr_d  = addr_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    ctrl_d       = ctrl_a[win];
                    addr_d       = addr_a[win];
                    en_d         = 1'b1;
                    last_d       = win;
                    cnt_d        = '0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (MEM_HANDSHAKE) begin
                    rd_d    = MEM_READ;
                    done_d  = grant_q;
                    en_d    = 1'b0;
                    state_d = S_RELEASE;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = grant_q;
                    seen_d  = 1'b1;
                    en_d    = 1'b0;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RELEASE: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rd_q    <= '0;
            seen_q  <= 1'b0;
            en_q    <= 1'b0;
            ctrl_q  <= '0;
            addr_q  <= '0;
            last_q  <= IW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            seen_q  <= seen_d;
            en_q    <= en_d;
            ctrl_q  <= ctrl_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign GRANT        = grant_q;
    assign DONE         = done_q;
    assign ERR          = err_q;
    assign RD_DATA      = rd_q;
    assign BUSY         = (state_q != S_IDLE);
    assign TIMEOUT_SEEN = seen_q;
    // Enable is gated by reset so the controller is released without waiting for an edge.
    assign MEM_ENABLE   = en_q & RESET;
    assign MEM_CTRL     = ctrl_q;
    assign MEM_ADDRESS  = addr_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: vector table, corner sequences,
// and randomized transactions against a transaction-level model.
module tb_mem_access_arbiter;

    localparam int NREQ = 4;
    localparam int TO   = 10;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic [3:0]    REQ = '0;
    logic [11:0]   REQ_CTRL = '0;
    logic [191:0]  REQ_ADDRESS = '0;
    logic [3:0]    GRANT, DONE, ERR;
    logic [47:0]   RD_DATA;
    logic          BUSY, TIMEOUT_SEEN, MEM_ENABLE;
    logic [2:0]    MEM_CTRL;
    logic [47:0]   MEM_ADDRESS;
    logic [47:0]   MEM_READ = '0;
    logic          MEM_HANDSHAKE = 1'b0;

    mem_access_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_CTRL(REQ_CTRL),
        .REQ_ADDRESS(REQ_ADDRESS), .GRANT(GRANT), .DONE(DONE), .ERR(ERR),
        .RD_DATA(RD_DATA), .BUSY(BUSY), .TIMEOUT_SEEN(TIMEOUT_SEEN),
        .MEM_ENABLE(MEM_ENABLE), .MEM_CTRL(MEM_CTRL),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_READ(MEM_READ),
        .MEM_HANDSHAKE(MEM_HANDSHAKE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    int          m_last;
    logic        m_seen;
    logic [47:0] m_rd;

    typedef struct {
        logic [3:0]  req;
        int          k;
        logic [47:0] rdat;
        logic [2:0]  c;
        logic [47:0] a;
        bit          drop;
        bit          stale;
        logic [3:0]  eg;
        bit          eerr;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    function automatic logic [3:0] rr_pick(input int last, input logic [3:0] req);
        for (int d = 1; d <= NREQ; d++) begin
            int idx;
            idx = (last + d) % NREQ;
            if (req[idx]) return 4'(1 << idx);
        end
        return 4'b0;
    endfunction

    function automatic int oh2i(input logic [3:0] g);
        for (int i = 0; i < NREQ; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic drive_lanes(input logic [3:0] g, input logic [2:0] c,
                               input logic [47:0] a);
        for (int i = 0; i < NREQ; i++) begin
            REQ_CTRL[3*i +: 3]     = g[i] ? c : ~c;
            REQ_ADDRESS[48*i +: 48] = g[i] ? a : ~a;
        end
    endtask

    task automatic scramble_lanes();
        for (int i = 0; i < NREQ; i++) begin
            REQ_CTRL[3*i +: 3]      = 3'($urandom);
            REQ_ADDRESS[48*i +: 48] = 48'({$urandom, $urandom});
        end
    endtask

    // k: WAIT cycle index (0 = first WAIT edge) at which HANDSHAKE is first seen.
    task automatic txn(input string nm, input vec_t v);
        int n;
        int nexp;
        bit got;
        bit hold_ok;
        REQ = v.req;
        drive_lanes(v.eg, v.c, v.a);
        MEM_HANDSHAKE = v.stale;
        MEM_READ = v.rdat;
        step();
        chk({nm, " grant"}, 64'(GRANT), 64'(v.eg));
        chk({nm, " en"}, 64'(MEM_ENABLE), 64'd1);
        chk({nm, " addr"}, 64'(MEM_ADDRESS), 64'(v.a));
        chk({nm, " ctrl"}, 64'(MEM_CTRL), 64'(v.c));
        scramble_lanes();
        n = 0;
        got = 0;
        hold_ok = 1;
        while (!got && n < TO + 6) begin
            MEM_HANDSHAKE = (n >= 1 + v.k) || (v.stale && n == 0);
            if (v.drop && n == 2) REQ = REQ & ~v.eg;
            step();
            n++;
            got = (DONE != 0) || (ERR != 0);
            if (MEM_ADDRESS !== v.a || MEM_CTRL !== v.c || GRANT !== v.eg ||
                MEM_ENABLE !== !got || BUSY !== 1'b1 ||
                (DONE != 0 && ERR != 0))
                hold_ok = 0;
        end
        nexp = v.eerr ? TO + 1 : v.k + 2;
        if (v.eerr) m_seen = 1'b1;
        else m_rd = v.rdat;
        chk({nm, " latency"}, 64'(n), 64'(nexp));
        chk({nm, " done"}, 64'(DONE), v.eerr ? 64'd0 : 64'(v.eg));
        chk({nm, " err"}, 64'(ERR), v.eerr ? 64'(v.eg) : 64'd0);
        chk({nm, " rd_data"}, 64'(RD_DATA), 64'(m_rd));
        chk({nm, " seen"}, 64'(TIMEOUT_SEEN), 64'(m_seen));
        chk({nm, " hold"}, 64'(hold_ok), 64'd1);
        step();
        chk({nm, " release"}, 64'({GRANT, DONE, ERR, BUSY, MEM_ENABLE}), 64'd0);
        m_last = oh2i(v.eg);
    endtask

    initial begin
        bit   bad;
        vec_t r;
        tbl[0]  = '{4'b1111, 0, 48'h111, 3'd1, 48'h1000, 0, 0, 4'b0001, 0};
        tbl[1]  = '{4'b1111, 2, 48'h222, 3'd2, 48'h2000, 0, 0, 4'b0010, 0};
        tbl[2]  = '{4'b1111, 1, 48'h333, 3'd3, 48'h3000, 0, 0, 4'b0100, 0};
        tbl[3]  = '{4'b1111, 0, 48'h444, 3'd4, 48'h4000, 0, 0, 4'b1000, 0};
        tbl[4]  = '{4'b1111, 3, 48'h555, 3'd5, 48'h5000, 0, 0, 4'b0001, 0};
        tbl[5]  = '{4'b1111, 1, 48'h666, 3'd6, 48'h6000, 0, 0, 4'b0010, 0};
        tbl[6]  = '{4'b1111, 0, 48'h777, 3'd7, 48'h7000, 0, 0, 4'b0100, 0};
        tbl[7]  = '{4'b1111, 2, 48'h888, 3'd1, 48'h8000, 0, 0, 4'b1000, 0};
        tbl[8]  = '{4'b0100, 1, 48'hABCD, 3'd0, 48'h5, 0, 0, 4'b0100, 0};
        tbl[9]  = '{4'b1010, 12, 48'hDEAD, 3'd2, 48'h9000, 0, 0, 4'b1000, 1};
        tbl[10] = '{4'b1010, 0, 48'h1234, 3'd3, 48'hA000, 0, 0, 4'b0010, 0};
        tbl[11] = '{4'b0001, 9, 48'h5678, 3'd4, 48'hB000, 0, 0, 4'b0001, 0};
        tbl[12] = '{4'b0110, 4, 48'h9ABC, 3'd5, 48'hC000, 1, 0, 4'b0010, 0};
        tbl[13] = '{4'b0110, 0, 48'hCAFE, 3'd6, 48'hD000, 0, 0, 4'b0100, 0};
        tbl[14] = '{4'b1001, 3, 48'hBEEF, 3'd7, 48'hE000, 0, 1, 4'b1000, 0};

        RESET = 1'b0;
        REQ = 4'b1111;
        drive_lanes(4'b0001, 3'd5, 48'h77);
        step();
        step();
        chk("rst outputs", 64'({GRANT, DONE, ERR, BUSY, MEM_ENABLE, TIMEOUT_SEEN}), 64'd0);
        chk("rst rd_data", 64'(RD_DATA), 64'd0);
        chk("rst mem_addr", 64'({MEM_CTRL, MEM_ADDRESS}), 64'd0);
        REQ = 4'b0000;
        RESET = 1'b1;
        step();
        chk("idle no grant", 64'({GRANT, BUSY}), 64'd0);
        m_last = NREQ - 1;
        m_seen = 1'b0;
        m_rd = '0;

        for (int i = 0; i < 15; i++) txn($sformatf("v%0d", i), tbl[i]);

        REQ = 4'b0010;
        drive_lanes(4'b0010, 3'd1, 48'h42);
        MEM_HANDSHAKE = 1'b0;
        step();
        step();
        step();
        chk("wrst en before", 64'(MEM_ENABLE), 64'd1);
        RESET = 1'b0;
        #1;
        chk("wrst en now", 64'(MEM_ENABLE), 64'd0);
        step();
        chk("wrst outputs", 64'({GRANT, DONE, ERR, BUSY, MEM_ENABLE, TIMEOUT_SEEN}), 64'd0);
        chk("wrst data", 64'(RD_DATA), 64'd0);
        chk("wrst addr", 64'({MEM_CTRL, MEM_ADDRESS}), 64'd0);
        MEM_HANDSHAKE = 1'b1;
        REQ = 4'b0000;
        RESET = 1'b1;
        bad = 0;
        repeat (3) begin
            step();
            if (DONE != 0 || ERR != 0 || BUSY != 0) bad = 1;
        end
        chk("wrst no done", 64'(bad), 64'd0);
        MEM_HANDSHAKE = 1'b0;
        m_last = NREQ - 1;
        m_seen = 1'b0;
        m_rd = '0;

        for (int i = 0; i < 40; i++) begin
            r.req   = 4'($urandom_range(1, 15));
            r.k     = int'($urandom_range(0, 12));
            r.rdat  = 48'({$urandom, $urandom});
            r.c     = 3'($urandom);
            r.a     = 48'({$urandom, $urandom});
            r.drop  = 1'($urandom_range(0, 1));
            r.stale = 1'($urandom_range(0, 1));
            r.eg    = rr_pick(m_last, r.req);
            r.eerr  = (r.k >= TO);
            txn($sformatf("r%0d", i), r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
